// File: rtl/shift_add_mul_arbiter_if.sv
// Requester and response bus of the shared shift-add multiplier.
// master: requester/consumer side. slave: arbiter/multiplier side.
interface shift_add_mul_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [2*WIDTH-1:0]    rsp_product;
   logic [IDW-1:0]        rsp_id;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_product, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_product, rsp_id
   );
endinterface

// File: rtl/shift_add_mul_arbiter.sv
// Round-robin arbiter in front of one sequential shift-add multiplier.
// A granted operand pair is multiplied in WIDTH steps and returned with
// the owning requester's index on a valid/ready response port.
module shift_add_mul_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   shift_add_mul_arbiter_if.slave bus,
   output logic                  busy
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(WIDTH);
   localparam int AW  = $clog2(NREQ*WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]       id_q, id_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [2*WIDTH:0]     acc_q, acc_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [2*WIDTH-1:0]   rsp_product_q, rsp_product_d;
   logic [IDW-1:0]       rsp_id_q, rsp_id_d;

   logic                 any_valid;
   logic [IDW-1:0]       grant;
   logic [WIDTH-1:0]     grant_a;
   logic [WIDTH-1:0]     grant_b;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH:0]     acc_step;

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      int idx;
      idx       = 0;
      any_valid = 1'b0;
      grant     = '0;
      grant_a   = '0;
      grant_b   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NREQ;
         if (!any_valid && bus.req_valid[IDW'(idx)]) begin
            any_valid = 1'b1;
            grant     = IDW'(idx);
            grant_a   = bus.req_a[AW'(idx*WIDTH) +: WIDTH];
            grant_b   = bus.req_b[AW'(idx*WIDTH) +: WIDTH];
         end
      end
   end

   // One-hot ready at the grant, only while idle; masked during reset so no
   // handshake is signalled on an edge that cannot accept.
   always_comb begin
      bus.req_ready = '0;
      if (state_q == IDLE && any_valid && !reset) begin
         bus.req_ready[grant] = 1'b1;
      end
   end

   // One multiply step: conditional add into the upper half, then shift right.
   always_comb begin
      sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
      if (acc_q[0]) begin
         acc_step = {sum, acc_q[WIDTH-1:0]} >> 1;
      end else begin
         acc_step = acc_q >> 1;
      end
   end

   // Sequencing FSM: accept in IDLE, WIDTH steps in RUN, hold result in DONE.
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      id_d          = id_q;
      a_d           = a_q;
      acc_d         = acc_q;
      count_d       = count_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_product_d = rsp_product_q;
      rsp_id_d      = rsp_id_q;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               a_d      = grant_a;
               acc_d    = {{(WIDTH+1){1'b0}}, grant_b};
               id_d     = grant;
               rr_ptr_d = grant;
               count_d  = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            acc_d   = acc_step;
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH-1)) begin
               rsp_product_d = acc_step[2*WIDTH-1:0];
               rsp_id_d      = id_q;
               rsp_valid_d   = 1'b1;
               state_d       = DONE;
            end
         end
         DONE: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any multiply in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         rr_ptr_q      <= IDW'(NREQ-1);
         id_q          <= '0;
         a_q           <= '0;
         acc_q         <= '0;
         count_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_product_q <= '0;
         rsp_id_q      <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         id_q          <= id_d;
         a_q           <= a_d;
         acc_q         <= acc_d;
         count_q       <= count_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_product_q <= rsp_product_d;
         rsp_id_q      <= rsp_id_d;
      end
   end

   assign busy            = (state_q != IDLE);
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_product = rsp_product_q;
   assign bus.rsp_id      = rsp_id_q;
endmodule

// File: tb/tb_shift_add_mul_arbiter.sv
// Bench for shift_add_mul_arbiter: directed scenarios plus random
// transactions against a round-robin / integer-multiply reference model.
module tb_shift_add_mul_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic busy;

   shift_add_mul_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   shift_add_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int last_g;
   int ta  [NREQ];
   int tbv [NREQ];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference arbiter: rotate the requester list to start after the last
   // winner and take the first one that is asking.
   function automatic int rr_pick(input logic [NREQ-1:0] mask, input int last);
      int order[$];
      for (int k = 1; k <= NREQ; k++) order.push_back((last + k) % NREQ);
      foreach (order[j]) if (mask[order[j]]) return order[j];
      return -1;
   endfunction

   task automatic drive(input logic [NREQ-1:0] mask);
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(ta[i]);
         bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(tbv[i]);
      end
      bus.req_valid = mask;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < NREQ; i++) begin
         ta[i]  = int'($urandom_range(0, (1 << WIDTH) - 1));
         tbv[i] = int'($urandom_range(0, (1 << WIDTH) - 1));
      end
   endtask

   task automatic wait_rsp(input int exp_id, input int exp_prod, input bit hs);
      int lat;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.rsp_valid && lat < 20);
      check("latency", lat, WIDTH);
      check("product", 32'(bus.rsp_product), exp_prod);
      check("rsp_id", 32'(bus.rsp_id), exp_id);
      check("busy_done", 32'(busy), 1);
      if (hs) begin
         bus.rsp_ready = 1'b1;
         tick();
         bus.rsp_ready = 1'b0;
         check("rsp_drop", 32'(bus.rsp_valid), 0);
         check("busy_idle", 32'(busy), 0);
      end
   endtask

   // Single request with the given valid mask; operands are scrambled right
   // after the handshake to show they no longer matter.
   task automatic txn(input logic [NREQ-1:0] mask);
      int g, ep;
      g = rr_pick(mask, last_g);
      drive(mask);
      #1;
      check("grant", 32'(bus.req_ready), 32'(1) << g);
      ep = ta[g] * tbv[g];
      tick();
      last_g = g;
      rand_ops();
      drive('0);
      check("busy_run", 32'(busy), 1);
      check("ready_run", 32'(bus.req_ready), 0);
      wait_rsp(g, ep, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(bus.req_ready), 0);
      check({tag, "_rvalid"}, 32'(bus.rsp_valid), 0);
      check({tag, "_prod"}, 32'(bus.rsp_product), 0);
      check({tag, "_id"}, 32'(bus.rsp_id), 0);
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      int g, ep, g2, ep2, cyc, prev, lat;
      logic [2*WIDTH-1:0] held_p;

      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin ta[i] = 0; tbv[i] = 0; end

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      check_reset_outputs("rst_hi");
      reset = 1'b0;
      last_g = NREQ - 1;
      #1;
      check_reset_outputs("rst_lo");

      // 3 x 5 from requester 0
      ta[0] = 3; tbv[0] = 5;
      txn(4'b0001);

      // Boundary operands
      ta[0] = 15; tbv[0] = 15; txn(4'b0001);
      ta[0] = 0;  tbv[0] = 9;  txn(4'b0001);
      ta[0] = 9;  tbv[0] = 1;  txn(4'b0001);

      // All requesters asking: rotating grants, fixed spacing
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      last_g = NREQ - 1;
      ta[0] = 3;  tbv[0] = 5;
      ta[1] = 7;  tbv[1] = 9;
      ta[2] = 11; tbv[2] = 13;
      ta[3] = 15; tbv[3] = 2;
      drive(4'b1111);
      bus.rsp_ready = 1'b1;
      cyc  = 0;
      prev = 0;
      for (int r = 0; r < 5; r++) begin
         lat = 0;
         do begin
            tick();
            cyc++;
            lat++;
         end while (!bus.rsp_valid && lat < 20);
         check("rr_seen", 32'(bus.rsp_valid), 1);
         g = rr_pick(4'b1111, last_g);
         last_g = g;
         check("rr_id", 32'(bus.rsp_id), g);
         check("rr_prod", 32'(bus.rsp_product), ta[g] * tbv[g]);
         if (r > 0) check("rr_spacing", cyc - prev, WIDTH + 2);
         prev = cyc;
         if (r == 4) drive('0);
      end
      tick();
      check("rr_end_busy", 32'(busy), 0);
      check("rr_end_rvalid", 32'(bus.rsp_valid), 0);
      bus.rsp_ready = 1'b0;

      // Stalled consumer: response held for 10 cycles, no new grants
      rand_ops();
      g = rr_pick(4'b0010, last_g);
      drive(4'b0010);
      #1;
      check("stall_grant", 32'(bus.req_ready), 32'(1) << g);
      ep = ta[g] * tbv[g];
      tick();
      last_g = g;
      wait_rsp(g, ep, 1'b0);
      held_p = bus.rsp_product;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("stall_rvalid", 32'(bus.rsp_valid), 1);
         check("stall_prod", 32'(bus.rsp_product), 32'(held_p));
         check("stall_id", 32'(bus.rsp_id), g);
         check("stall_ready", 32'(bus.req_ready), 0);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      g2 = rr_pick(4'b0010, last_g);
      check("stall_release_rvalid", 32'(bus.rsp_valid), 0);
      check("stall_release_busy", 32'(busy), 0);
      check("stall_regrant", 32'(bus.req_ready), 32'(1) << g2);
      ep2 = ta[g2] * tbv[g2];
      tick();
      last_g = g2;
      check("stall_regrant_busy", 32'(busy), 1);
      drive('0);
      wait_rsp(g2, ep2, 1'b1);

      // Reset two steps into a multiply, then a fresh grant to requester 2
      rand_ops();
      drive(4'b0010);
      tick();
      drive(4'b0100);
      tick();
      tick();
      reset = 1'b1;
      tick();
      check_reset_outputs("abort");
      reset = 1'b0;
      last_g = NREQ - 1;
      g = rr_pick(4'b0100, last_g);
      #1;
      check("abort_grant", 32'(bus.req_ready), 32'(1) << g);
      ep = ta[g] * tbv[g];
      tick();
      last_g = g;
      bus.req_valid = '0;
      wait_rsp(g, ep, 1'b1);

      // Operands of the granted requester change during the multiply
      ta[3] = 13; tbv[3] = 11;
      txn(4'b1000);

      // Random masks and operands
      for (int n = 0; n < 12; n++) begin
         rand_ops();
         txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
